// File: rtl/rom_rr_arbiter.sv
// Round-robin front end sharing one combinational ROM among NUM_REQ requesters.
// One read per two cycles: accept -> READ (ROM sampled) -> RESP (registered pulse).
module rom_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t          state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   win_idx;
  logic            win_found;
  logic            accept;

  // Index of the k-th candidate after base, wrapping at NUM_REQ.
  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
    int s;
    s = int'(base) + 1 + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return GW'(s);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[rr_idx(last_grant, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(last_grant, k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (win_found) begin
          req_ready = ONE << win_idx;
          accept    = 1'b1;
          state_nxt = READ;
        end else begin
          state_nxt = IDLE;
        end
      end
      READ:    state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Address register only moves on accept so the ROM input never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      grant_q    <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      rsp_valid  <= '0;
      rsp_data   <= '0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        grant_q    <= win_idx;
        last_grant <= win_idx;
      end
      if (state == READ) begin
        rsp_valid <= ONE << grant_q;
        rsp_data  <= rom_data;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

  assign rom_address = addr_q;
  assign busy        = (state == READ);

endmodule
